// File: rtl/cheat_pkg.sv
// Shared definitions for the cheat-code loader: code word layout, record size and FSM states.
package cheat_pkg;

    localparam int CODE_W    = 129;
    localparam int CLK_BIT   = 128;
    localparam int FLAGS_LSB = 96;
    localparam int ADDR_LSB  = 64;
    localparam int COMP_LSB  = 32;
    localparam int DATA_LSB  = 0;
    localparam int REC_BYTES = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLEAR     = 3'd1,
        COLLECT   = 3'd2,
        STROBE_HI = 3'd3,
        STROBE_LO = 3'd4
    } state_t;

    // Bit position of record byte idx: word idx/4 selects the field, byte idx%4 is little-endian within it.
    function automatic logic [6:0] byte_lsb(input logic [3:0] idx);
        logic [6:0] k_off;
        k_off = {2'b00, idx[1:0], 3'b000};
        case (idx[3:2])
            2'd0:    byte_lsb = 7'(FLAGS_LSB) + k_off;
            2'd1:    byte_lsb = 7'(ADDR_LSB) + k_off;
            2'd2:    byte_lsb = 7'(COMP_LSB) + k_off;
            default: byte_lsb = 7'(DATA_LSB) + k_off;
        endcase
    endfunction

endpackage

// File: rtl/cheat_byte_assembler.sv
// Collects 16 file bytes into a 128-bit shadow record with little-endian word placement.
// o_rec_next is the shadow with the current byte merged, so the final byte is visible in the copy edge.
module cheat_byte_assembler
    import cheat_pkg::*;
(
    input  logic         clk,
    input  logic         resetn,
    input  logic         i_clr,
    input  logic         i_wr,
    input  logic [7:0]   i_data,
    output logic [127:0] o_rec_next,
    output logic         o_rec_done,
    output logic         o_rec_zero
);

    logic [3:0]   r_index;
    logic [127:0] r_shadow;
    logic [127:0] w_rec_next;
    logic [6:0]   w_lsb;

    // Merge the incoming byte into a copy of the shadow at its little-endian position.
    always_comb begin
        w_rec_next = r_shadow;
        w_lsb      = byte_lsb(r_index);
        w_rec_next[w_lsb +: 8] = i_data;
    end

    assign o_rec_next = w_rec_next;
    assign o_rec_done = i_wr && (r_index == 4'(REC_BYTES - 1));
    assign o_rec_zero = (w_rec_next == 128'd0);

    // Byte index and shadow storage; a clear discards any partial record.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_index  <= 4'd0;
            r_shadow <= 128'd0;
        end else if (i_clr) begin
            r_index  <= 4'd0;
        end else if (i_wr) begin
            r_shadow <= w_rec_next;
            r_index  <= r_index + 4'd1;
        end
    end

endmodule

// File: rtl/cheat_loader.sv
// Cheat file loader: assembles 16-byte records into the 129-bit matcher code word and strobes its clock bit.
// Optional macro CHEAT_ZERO_SKIP_EN: all-zero records are treated as padding and never presented.
module cheat_loader
    import cheat_pkg::*;
#(
    parameter int MAX_CODES   = 32,
    parameter int HOLD_CYCLES = 4,
    parameter int CLR_CYCLES  = 2
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           dl_start,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [7:0]                     in_data,
    input  logic                           in_last,
    output logic [CODE_W-1:0]              code_out,
    output logic                           codes_reset,
    output logic                           busy,
    output logic [$clog2(MAX_CODES+1)-1:0] code_count,
    output logic                           overflow,
    output logic                           err_partial
);

    localparam int COUNT_W = $clog2(MAX_CODES + 1);
    localparam int TMR_MAX = (HOLD_CYCLES > CLR_CYCLES) ? HOLD_CYCLES : CLR_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

`ifdef CHEAT_ZERO_SKIP_EN
    localparam logic SKIP_ZERO = 1'b1;
`else
    localparam logic SKIP_ZERO = 1'b0;
`endif

    state_t               r_state;
    logic [TMR_W-1:0]     r_timer;
    logic [CLK_BIT-1:0]   r_code;
    logic                 r_clk_bit;
    logic                 r_codes_reset;
    logic                 r_in_ready;
    logic                 r_busy;
    logic [COUNT_W-1:0]   r_count;
    logic                 r_overflow;
    logic                 r_err_partial;
    logic                 r_last;

    logic                 w_xfer;
    logic                 w_asm_clr;
    logic [127:0]         w_rec_next;
    logic                 w_rec_done;
    logic                 w_rec_zero;

    assign w_xfer    = in_valid && r_in_ready;
    assign w_asm_clr = dl_start || (w_xfer && in_last);

    cheat_byte_assembler u_asm (
        .clk        (clk),
        .resetn     (resetn),
        .i_clr      (w_asm_clr),
        .i_wr       (w_xfer),
        .i_data     (in_data),
        .o_rec_next (w_rec_next),
        .o_rec_done (w_rec_done),
        .o_rec_zero (w_rec_zero)
    );

    // Loader FSM; every output is a register so the matcher never sees combinational glitches.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state       <= IDLE;
            r_timer       <= '0;
            r_code        <= '0;
            r_clk_bit     <= 1'b0;
            r_codes_reset <= 1'b0;
            r_in_ready    <= 1'b0;
            r_busy        <= 1'b0;
            r_count       <= '0;
            r_overflow    <= 1'b0;
            r_err_partial <= 1'b0;
            r_last        <= 1'b0;
        end else if (dl_start) begin
            // A new download always wins, even mid-record or mid-strobe.
            r_state       <= CLEAR;
            r_timer       <= '0;
            r_clk_bit     <= 1'b0;
            r_codes_reset <= 1'b1;
            r_in_ready    <= 1'b0;
            r_busy        <= 1'b1;
            r_count       <= '0;
            r_overflow    <= 1'b0;
            r_err_partial <= 1'b0;
            r_last        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                end
                CLEAR: begin
                    if (r_timer == TMR_W'(CLR_CYCLES - 1)) begin
                        r_state       <= COLLECT;
                        r_codes_reset <= 1'b0;
                        r_in_ready    <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                COLLECT: begin
                    if (w_xfer && w_rec_done) begin
                        r_code <= w_rec_next;
                        if (SKIP_ZERO && w_rec_zero) begin
                            if (in_last) begin
                                r_state    <= IDLE;
                                r_in_ready <= 1'b0;
                                r_busy     <= 1'b0;
                            end
                        end else if (r_count < COUNT_W'(MAX_CODES)) begin
                            r_state    <= STROBE_HI;
                            r_timer    <= '0;
                            r_clk_bit  <= 1'b1;
                            r_in_ready <= 1'b0;
                            r_count    <= r_count + COUNT_W'(1);
                            r_last     <= in_last;
                        end else begin
                            r_overflow <= 1'b1;
                            if (in_last) begin
                                r_state    <= IDLE;
                                r_in_ready <= 1'b0;
                                r_busy     <= 1'b0;
                            end
                        end
                    end else if (w_xfer && in_last) begin
                        r_err_partial <= 1'b1;
                        r_state       <= IDLE;
                        r_in_ready    <= 1'b0;
                        r_busy        <= 1'b0;
                    end
                end
                STROBE_HI: begin
                    if (r_timer == TMR_W'(HOLD_CYCLES - 1)) begin
                        r_state   <= STROBE_LO;
                        r_timer   <= '0;
                        r_clk_bit <= 1'b0;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                STROBE_LO: begin
                    if (r_timer == TMR_W'(HOLD_CYCLES - 1)) begin
                        if (r_last) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state    <= COLLECT;
                            r_in_ready <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    r_clk_bit     <= 1'b0;
                    r_codes_reset <= 1'b0;
                    r_in_ready    <= 1'b0;
                    r_busy        <= 1'b0;
                end
            endcase
        end
    end

    assign code_out    = {r_clk_bit, r_code};
    assign codes_reset = r_codes_reset;
    assign in_ready    = r_in_ready;
    assign busy        = r_busy;
    assign code_count  = r_count;
    assign overflow    = r_overflow;
    assign err_partial = r_err_partial;

endmodule

// File: tb/tb_cheat_loader.sv
// Directed self-checking bench for cheat_loader (default parameters: 32 codes, hold 4, clear 2).
module tb_cheat_loader;

    logic         clk;
    logic         resetn;
    logic         dl_start;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         in_last;
    logic [128:0] code_out;
    logic         codes_reset;
    logic         busy;
    logic [5:0]   code_count;
    logic         overflow;
    logic         err_partial;

    int n_checks = 0;
    int n_fails  = 0;
    int rise_cnt = 0;
    logic prev_bit = 1'b0;
    int base;

    cheat_loader dut (
        .clk         (clk),
        .resetn      (resetn),
        .dl_start    (dl_start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .code_out    (code_out),
        .codes_reset (codes_reset),
        .busy        (busy),
        .code_count  (code_count),
        .overflow    (overflow),
        .err_partial (err_partial)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rising edges of the matcher clock bit as seen between active edges.
    always @(negedge clk) begin
        if (code_out[128] && !prev_bit) rise_cnt <= rise_cnt + 1;
        prev_bit <= code_out[128];
    end

    task automatic chk(input string tag, input logic [128:0] obs, input logic [128:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_dl();
        dl_start = 1'b1;
        @(negedge clk);
        dl_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        int t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("ready_timeout", in_ready, 1'b1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // file holds the bytes in file order, first byte in the top 8 bits.
    task automatic send_record(input logic [127:0] file, input logic last);
        for (int i = 0; i < 16; i++) begin
            send_byte(file[127-8*i -: 8], last && (i == 15));
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (busy) chk("idle_timeout", busy, 1'b0);
    endtask

    initial begin
        resetn   = 1'b0;
        dl_start = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        chk("rst_code_out", code_out, 129'd0);
        chk("rst_codes_reset", codes_reset, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_count", code_count, 6'd0);
        chk("rst_flags", {overflow, err_partial}, 2'b00);

        // Download start: two clear cycles, then ready.
        pulse_dl();
        chk("clr_c0", {codes_reset, busy, in_ready}, 3'b110);
        @(negedge clk);
        chk("clr_c1", {codes_reset, busy, in_ready}, 3'b110);
        @(negedge clk);
        chk("clr_done", {codes_reset, busy, in_ready}, 3'b011);

        // One record with little-endian words, last on final byte.
        send_record(128'h01000000_34120000_AA000000_55000000, 1'b1);
        chk("rec1_code", code_out, {1'b1, 128'h00000001_00001234_000000AA_00000055});
        for (int i = 0; i < 4; i++) begin
            chk("rec1_hi", code_out[128], 1'b1);
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            chk("rec1_lo", {code_out[128], in_ready}, 2'b00);
            @(negedge clk);
        end
        chk("rec1_idle", busy, 1'b0);
        chk("rec1_count", code_count, 6'd1);
        chk("rec1_hold", code_out[127:0], 128'h00000001_00001234_000000AA_00000055);

        // 33 records against a capacity of 32.
        base = rise_cnt;
        pulse_dl();
        for (int r = 0; r < 33; r++) begin
            send_record({8'(r + 1), 120'h000000_11223344_55667788_99AABBCC}, r == 32);
        end
        wait_idle();
        repeat (2) @(negedge clk);
        chk("ovf_rises", rise_cnt - base, 32);
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_count", code_count, 6'd32);

        // File ends on the 10th byte of a record.
        pulse_dl();
        chk("part_ovf_clr", overflow, 1'b0);
        base = rise_cnt;
        for (int i = 0; i < 10; i++) send_byte(8'(i + 1), i == 9);
        chk("part_err", err_partial, 1'b1);
        chk("part_idle", {busy, in_ready}, 2'b00);
        repeat (10) @(negedge clk);
        chk("part_rises", rise_cnt - base, 0);
        chk("part_count", code_count, 6'd0);

        // Restart while the clock bit is high.
        pulse_dl();
        chk("mid_err_clr", err_partial, 1'b0);
        send_record(128'h07000000_00000000_00000000_00000001, 1'b0);
        chk("mid_hi", code_out[128], 1'b1);
        @(negedge clk);
        pulse_dl();
        chk("mid_fall", code_out[128], 1'b0);
        chk("mid_clr", codes_reset, 1'b1);
        chk("mid_count", code_count, 6'd0);

        // Zero padding record followed by a real record.
        base = rise_cnt;
        pulse_dl();
        send_record(128'd0, 1'b0);
        send_record(128'h02000000_00000000_00000000_00000000, 1'b1);
        wait_idle();
        @(negedge clk);
`ifdef CHEAT_ZERO_SKIP_EN
        chk("zero_rises", rise_cnt - base, 1);
        chk("zero_count", code_count, 6'd1);
`else
        chk("zero_rises", rise_cnt - base, 2);
        chk("zero_count", code_count, 6'd2);
`endif
        chk("zero_code", code_out[127:0], 128'h00000002_00000000_00000000_00000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
